// File: rtl/usb_buffer_arbiter.sv
// usb_buffer_arbiter: hands the USB packet buffer and control register between the USB engine and the core by ownership token.
module usb_buffer_arbiter #(
  parameter int DEPTH_WORDS    = 256,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic                  clk24,
  input  logic                  reset,
  input  logic                  core_en,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [3:0]            core_we,
  input  logic [31:0]           core_wdata,
  output logic [31:0]           core_rdata,
  output logic                  core_rvalid,
  output logic                  core_err,
  input  logic [1:0]            ctrl_we,
  input  logic [15:0]           ctrl_wdata,
  input  logic                  usb_en,
  input  logic [ADDR_WIDTH-1:0] usb_addr,
  input  logic                  usb_we,
  input  logic [31:0]           usb_wdata,
  output logic [31:0]           usb_rdata,
  output logic                  usb_rvalid,
  input  logic                  usb_got_packet,
  input  logic [15:0]           usb_control_in,
  output logic [15:0]           usb_control,
  output logic                  packet_ready,
  output logic                  usb_may_accept,
  output logic                  owner_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {USB_OWN, CORE_OWN, HANDOFF} state_e;
  state_e state_q, state_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic core_gnt, usb_gnt, core_rd, usb_rd;
  logic [3:0] wen;
  logic [31:0] wdata;
  logic [ADDR_WIDTH-1:0] addr;
  logic [TW-1:0] timer_q;
  logic [15:0] ctrl_q;
  logic [31:0] core_rdata_q, usb_rdata_q;
  logic core_rvalid_q, usb_rvalid_q, core_err_q, timeout_q;
  always_ff @(posedge clk24) begin
    if (reset) state_q <= USB_OWN;
    else state_q <= state_d;
  end
  // Only the event belonging to the current owner moves the token.
  always_comb begin
    state_d = state_q;
    if (state_q == USB_OWN && usb_got_packet) state_d = CORE_OWN;
    if (state_q == CORE_OWN && ctrl_we != 2'b00) state_d = HANDOFF;
    if (state_q == HANDOFF) state_d = USB_OWN;
  end
  always_comb begin
    packet_ready   = state_q == CORE_OWN;
    usb_may_accept = state_q == USB_OWN;
    core_gnt       = core_en && state_q == CORE_OWN;
    usb_gnt        = usb_en && state_q == USB_OWN;
    core_rd        = core_gnt && core_we == 4'b0000;
    usb_rd         = usb_gnt && !usb_we;
    addr           = core_gnt ? core_addr : usb_addr;
    wen            = core_gnt ? core_we : {4{usb_gnt && usb_we}};
    wdata          = core_gnt ? core_wdata : usb_wdata;
  end
  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk24) begin
    for (int b = 0; b < 4; b++)
      if (wen[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
  end
  always_ff @(posedge clk24) begin
    if (reset) begin
      core_rdata_q  <= '0;
      usb_rdata_q   <= '0;
      core_rvalid_q <= 1'b0;
      usb_rvalid_q  <= 1'b0;
      core_err_q    <= 1'b0;
    end else begin
      core_rvalid_q <= core_rd;
      usb_rvalid_q  <= usb_rd;
      core_err_q    <= core_en && state_q == USB_OWN;
      if (core_rd) core_rdata_q <= mem[addr];
      if (usb_rd) usb_rdata_q <= mem[addr];
    end
  end
  always_ff @(posedge clk24) begin
    if (reset) ctrl_q <= '0;
    else if (state_q == USB_OWN && usb_got_packet) ctrl_q <= usb_control_in;
    else if (state_q == CORE_OWN) begin
      if (ctrl_we[0]) ctrl_q[7:0] <= ctrl_wdata[7:0];
      if (ctrl_we[1]) ctrl_q[15:8] <= ctrl_wdata[15:8];
    end
  end
  // Timeout is advisory only; the core keeps the buffer until it writes control.
  always_ff @(posedge clk24) begin
    if (reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= state_q != CORE_OWN ? '0 : (timer_q == TMAX ? timer_q : timer_q + 1'b1);
      timeout_q <= state_q == HANDOFF ? 1'b0 : timeout_q | (state_q == CORE_OWN && timer_q == TMAX);
    end
  end
  assign core_rdata    = core_rdata_q;
  assign usb_rdata     = usb_rdata_q;
  assign core_rvalid   = core_rvalid_q;
  assign usb_rvalid    = usb_rvalid_q;
  assign core_err      = core_err_q;
  assign usb_control   = ctrl_q;
  assign owner_timeout = timeout_q;
endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// tb_usb_buffer_arbiter: scoreboard bench for the USB buffer ownership arbiter.
module tb_usb_buffer_arbiter;
  logic clk24 = 1'b0;
  logic reset = 1'b1;
  logic core_en = 1'b0, usb_en = 1'b0, usb_we = 1'b0, usb_got_packet = 1'b0;
  logic [7:0] core_addr = '0, usb_addr = '0;
  logic [3:0] core_we = '0;
  logic [31:0] core_wdata = '0, usb_wdata = '0;
  logic [1:0] ctrl_we = '0;
  logic [15:0] ctrl_wdata = '0, usb_control_in = '0;
  logic [31:0] core_rdata, usb_rdata;
  logic core_rvalid, core_err, usb_rvalid, packet_ready, usb_may_accept, owner_timeout;
  logic [15:0] usb_control;
  logic [31:0] mem_m [256];
  logic [31:0] q_core[$], q_usb[$];
  logic [31:0] e;
  int checks = 0, failures = 0;

  usb_buffer_arbiter #(.DEPTH_WORDS(256), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
    .clk24(clk24), .reset(reset),
    .core_en(core_en), .core_addr(core_addr), .core_we(core_we), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid), .core_err(core_err),
    .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata),
    .usb_en(usb_en), .usb_addr(usb_addr), .usb_we(usb_we), .usb_wdata(usb_wdata),
    .usb_rdata(usb_rdata), .usb_rvalid(usb_rvalid),
    .usb_got_packet(usb_got_packet), .usb_control_in(usb_control_in),
    .usb_control(usb_control), .packet_ready(packet_ready),
    .usb_may_accept(usb_may_accept), .owner_timeout(owner_timeout)
  );

  always #5 clk24 = ~clk24;

  task automatic tick;
    @(posedge clk24);
    #1;
  endtask

  task automatic usb_acc(input logic [7:0] a, input logic we, input logic [31:0] d, input logic honoured);
    usb_en = 1'b1; usb_addr = a; usb_we = we; usb_wdata = d;
    if (honoured) begin
      if (we) mem_m[a] = d;
      else q_usb.push_back(mem_m[a]);
    end
    tick;
    usb_en = 1'b0; usb_we = 1'b0;
  endtask

  task automatic core_acc(input logic [7:0] a, input logic [3:0] we, input logic [31:0] d, input logic honoured);
    core_en = 1'b1; core_addr = a; core_we = we; core_wdata = d;
    if (honoured) begin
      if (we == 4'b0) q_core.push_back(mem_m[a]);
      for (int b = 0; b < 4; b++) if (we[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
    end
    tick;
    core_en = 1'b0; core_we = '0;
  endtask

  task automatic packet(input logic [15:0] c);
    usb_got_packet = 1'b1; usb_control_in = c;
    tick;
    usb_got_packet = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++; if (packet_ready !== 1'b0) begin failures++; $display("FAIL reset_packet_ready got=%b want=0", packet_ready); end
    checks++; if (usb_may_accept !== 1'b1) begin failures++; $display("FAIL reset_may_accept got=%b want=1", usb_may_accept); end
    checks++; if (usb_control !== 16'h0) begin failures++; $display("FAIL reset_control got=%h want=0000", usb_control); end
    checks++; if ({owner_timeout, core_rvalid, usb_rvalid, core_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", {owner_timeout, core_rvalid, usb_rvalid, core_err}); end
    checks++; if ({core_rdata, usb_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", {core_rdata, usb_rdata}); end
  endtask

  task automatic test_usb_rw;
    usb_acc(8'd3, 1'b1, 32'hDEADBEEF, 1'b1);
    checks++; if (usb_rvalid !== 1'b0) begin failures++; $display("FAIL usb_write_rvalid got=%b want=0", usb_rvalid); end
    usb_acc(8'd3, 1'b0, '0, 1'b1);
    e = q_usb.pop_front();
    checks++; if (usb_rvalid !== 1'b1 || usb_rdata !== e) begin failures++; $display("FAIL usb_read3 got=%b/%h want=1/%h", usb_rvalid, usb_rdata, e); end
    tick;
    checks++; if (usb_rvalid !== 1'b0 || usb_rdata !== e) begin failures++; $display("FAIL usb_rvalid_pulse got=%b/%h want=0/%h", usb_rvalid, usb_rdata, e); end
    checks++; if (packet_ready !== 1'b0) begin failures++; $display("FAIL usb_own_ready got=%b want=0", packet_ready); end
  endtask

  task automatic test_back_to_back;
    usb_acc(8'd0, 1'b1, 32'h0BADC0DE, 1'b1);
    usb_acc(8'd255, 1'b1, 32'h5A5A1234, 1'b1);
    usb_acc(8'd5, 1'b1, 32'h01020304, 1'b1);
    usb_acc(8'd0, 1'b0, '0, 1'b1);
    e = q_usb.pop_front();
    checks++; if (usb_rvalid !== 1'b1 || usb_rdata !== e) begin failures++; $display("FAIL b2b_read0 got=%b/%h want=1/%h", usb_rvalid, usb_rdata, e); end
    usb_acc(8'd255, 1'b0, '0, 1'b1);
    e = q_usb.pop_front();
    checks++; if (usb_rvalid !== 1'b1 || usb_rdata !== e) begin failures++; $display("FAIL b2b_read255 got=%b/%h want=1/%h", usb_rvalid, usb_rdata, e); end
    usb_acc(8'd7, 1'b1, 32'hFFFF0000, 1'b1);
    usb_acc(8'd7, 1'b0, '0, 1'b1);
    e = q_usb.pop_front();
    checks++; if (usb_rvalid !== 1'b1 || usb_rdata !== e) begin failures++; $display("FAIL b2b_wr_then_rd got=%b/%h want=1/%h", usb_rvalid, usb_rdata, e); end
  endtask

  task automatic test_core_while_usb;
    core_acc(8'd5, 4'hF, 32'hCAFEF00D, 1'b0);
    checks++; if (core_err !== 1'b1 || core_rvalid !== 1'b0) begin failures++; $display("FAIL core_err_write got=%b/%b want=1/0", core_err, core_rvalid); end
    tick;
    checks++; if (core_err !== 1'b0) begin failures++; $display("FAIL core_err_pulse got=%b want=0", core_err); end
    core_acc(8'd5, 4'h0, '0, 1'b0);
    checks++; if (core_err !== 1'b1 || core_rvalid !== 1'b0) begin failures++; $display("FAIL core_err_read got=%b/%b want=1/0", core_err, core_rvalid); end
    usb_acc(8'd5, 1'b0, '0, 1'b1);
    e = q_usb.pop_front();
    checks++; if (usb_rdata !== e || e !== 32'h01020304) begin failures++; $display("FAIL core_drop_ram got=%h want=01020304", usb_rdata); end
  endtask

  task automatic test_core_own;
    packet(16'h1234);
    checks++; if (packet_ready !== 1'b1 || usb_may_accept !== 1'b0) begin failures++; $display("FAIL got_packet_flags got=%b%b want=10", packet_ready, usb_may_accept); end
    checks++; if (usb_control !== 16'h1234) begin failures++; $display("FAIL got_packet_ctrl got=%h want=1234", usb_control); end
    core_acc(8'd3, 4'h0, '0, 1'b1);
    e = q_core.pop_front();
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF || e !== 32'hDEADBEEF) begin failures++; $display("FAIL core_read3 got=%b/%h want=1/deadbeef", core_rvalid, core_rdata); end
    core_acc(8'd3, 4'b0010, 32'h0000AB00, 1'b1);
    core_acc(8'd3, 4'h0, '0, 1'b1);
    e = q_core.pop_front();
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== e || e !== 32'hDEADABEF) begin failures++; $display("FAIL core_lane_write got=%h want=deadabef", core_rdata); end
    usb_acc(8'd3, 1'b1, 32'h11111111, 1'b0);
    usb_acc(8'd3, 1'b0, '0, 1'b0);
    checks++; if (usb_rvalid !== 1'b0) begin failures++; $display("FAIL usb_drop_rvalid got=%b want=0", usb_rvalid); end
    packet(16'h5555);
    checks++; if (usb_control !== 16'h1234 || packet_ready !== 1'b1) begin failures++; $display("FAIL ignore_packet got=%h/%b want=1234/1", usb_control, packet_ready); end
    core_acc(8'd3, 4'h0, '0, 1'b1);
    e = q_core.pop_front();
    checks++; if (core_rvalid !== 1'b1 || core_rdata !== e || core_err !== 1'b0) begin failures++; $display("FAIL usb_drop_ram got=%h err=%b want=%h err=0", core_rdata, core_err, e); end
  endtask

  task automatic test_handoff;
    ctrl_we = 2'b01; ctrl_wdata = 16'h00FF;
    usb_got_packet = 1'b1; usb_control_in = 16'h9999;
    tick;
    ctrl_we = '0; usb_got_packet = 1'b0;
    checks++; if (usb_control !== 16'h12FF) begin failures++; $display("FAIL ctrl_write got=%h want=12ff", usb_control); end
    checks++; if (packet_ready !== 1'b0 || usb_may_accept !== 1'b0) begin failures++; $display("FAIL handoff_flags got=%b%b want=00", packet_ready, usb_may_accept); end
    core_acc(8'd3, 4'h0, '0, 1'b0);
    checks++; if (core_err !== 1'b0 || core_rvalid !== 1'b0) begin failures++; $display("FAIL handoff_drop got=%b/%b want=0/0", core_err, core_rvalid); end
    checks++; if (usb_may_accept !== 1'b1 || packet_ready !== 1'b0) begin failures++; $display("FAIL handoff_len got=%b%b want=01", packet_ready, usb_may_accept); end
  endtask

  task automatic test_timeout;
    packet(16'hA5A5);
    for (int k = 1; k <= 10; k++) begin
      tick;
      checks++; if (owner_timeout !== (k >= 8)) begin failures++; $display("FAIL timeout_k%0d got=%b want=%b", k, owner_timeout, k >= 8); end
    end
    checks++; if (packet_ready !== 1'b1) begin failures++; $display("FAIL timeout_keeps_owner got=%b want=1", packet_ready); end
    ctrl_we = 2'b10; ctrl_wdata = 16'h3C00;
    tick;
    ctrl_we = '0;
    checks++; if (owner_timeout !== 1'b1 || usb_control !== 16'h3CA5) begin failures++; $display("FAIL timeout_handoff got=%b/%h want=1/3ca5", owner_timeout, usb_control); end
    tick;
    checks++; if (owner_timeout !== 1'b0 || usb_may_accept !== 1'b1) begin failures++; $display("FAIL timeout_clear got=%b/%b want=0/1", owner_timeout, usb_may_accept); end
  endtask

  task automatic test_reset_mid;
    packet(16'h7777);
    reset = 1'b1;
    core_acc(8'd3, 4'h0, '0, 1'b0);
    reset = 1'b0;
    checks++; if (core_rvalid !== 1'b0 || usb_control !== 16'h0) begin failures++; $display("FAIL reset_mid got=%b/%h want=0/0000", core_rvalid, usb_control); end
    checks++; if (usb_may_accept !== 1'b1 || packet_ready !== 1'b0) begin failures++; $display("FAIL reset_mid_owner got=%b%b want=01", packet_ready, usb_may_accept); end
    usb_acc(8'd3, 1'b0, '0, 1'b1);
    e = q_usb.pop_front();
    checks++; if (usb_rvalid !== 1'b1 || usb_rdata !== e || e !== 32'hDEADABEF) begin failures++; $display("FAIL ram_survives_reset got=%h want=deadabef", usb_rdata); end
  endtask

  initial begin
    test_reset;
    test_usb_rw;
    test_back_to_back;
    test_core_while_usb;
    test_core_own;
    test_handoff;
    test_timeout;
    test_reset_mid;
    checks++; if (q_core.size() != 0 || q_usb.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", q_core.size(), q_usb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
